// File: rtl/mem_access_responder_pkg.sv
// Shared constants for the memory access responder.
// State encodings, poison word and wait counter width.
package mem_resp_pkg;

  localparam int CNT_W = 4;

  localparam logic [4:0] S_IDLE    = 5'b00001;
  localparam logic [4:0] S_WR_WAIT = 5'b00010;
  localparam logic [4:0] S_WR_RESP = 5'b00100;
  localparam logic [4:0] S_RD_WAIT = 5'b01000;
  localparam logic [4:0] S_RD_RESP = 5'b10000;

  localparam logic [31:0] POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_access_responder_if.sv
// Request/response bus of the memory access responder.
// master drives requests, slave returns responses.
interface mem_access_responder_if;

  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_done;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    input  wr_done, rd_valid, rd_data,
    input  rd_done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    output wr_done, rd_valid, rd_data,
    output rd_done, err
  );

endinterface

// File: rtl/mem_access_responder_ram.sv
// DEPTH x 32 storage, one sync write and one sync read port.
// Contents are never reset.
module mem_resp_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read on the same edge as a write to that word sees the new data.
  always_ff @(posedge clk) begin
    if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_responder.sv
// Fixed-latency word memory responder with a one-entry pending read.
// Define ADDR_CHECK_EN to reject out-of-window or unaligned accesses.
module mem_access_responder
  import mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0008_1000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rstn,
  mem_access_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [4:0] ACC_WR =
    (WAIT_CYCLES == 0) ? S_WR_RESP : S_WR_WAIT;
  localparam logic [4:0] ACC_RD =
    (WAIT_CYCLES == 0) ? S_RD_RESP : S_RD_WAIT;

  function automatic logic [AW-1:0] widx(logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [31:0]      wr_dat_q, wr_dat_d;
  logic             wr_bad_q, wr_bad_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic             rd_bad_q, rd_bad_d;
  logic             pend_q, pend_d;
  logic [AW-1:0]    pend_idx_q, pend_idx_d;
  logic             pend_bad_q, pend_bad_d;
  logic             rd_has_q, rd_psn_q;
  logic             wr_chk, rd_chk;
  logic             ram_we, ram_re;
  logic [31:0]      ram_rdata;

`ifdef ADDR_CHECK_EN
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  function automatic logic addr_bad(logic [31:0] a);
    return (a < BASE_ADDR) || ({1'b0, a} >= LIMIT) ||
           (a[1:0] != 2'b00);
  endfunction

  assign wr_chk  = addr_bad(bus.wr_addr);
  assign rd_chk  = addr_bad(bus.rd_addr);
  assign bus.err = ((state_q == S_WR_RESP) && wr_bad_q) ||
                   ((state_q == S_RD_RESP) && rd_bad_q);
`else
  assign wr_chk  = 1'b0;
  assign rd_chk  = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_idx_d   = wr_idx_q;
    wr_dat_d   = wr_dat_q;
    wr_bad_d   = wr_bad_q;
    rd_idx_d   = rd_idx_q;
    rd_bad_d   = rd_bad_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    pend_bad_d = pend_bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.wr_en) begin
          state_d  = ACC_WR;
          cnt_d    = WAIT_INIT;
          wr_idx_d = widx(bus.wr_addr);
          wr_dat_d = bus.wr_data;
          wr_bad_d = wr_chk;
          if (bus.rd_en) begin
            pend_d     = 1'b1;
            pend_idx_d = widx(bus.rd_addr);
            pend_bad_d = rd_chk;
          end
        end else if (bus.rd_en) begin
          state_d  = ACC_RD;
          cnt_d    = WAIT_INIT;
          rd_idx_d = widx(bus.rd_addr);
          rd_bad_d = rd_chk;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q <= 1) begin
          state_d = S_WR_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_RESP: begin
        if (pend_q) begin
          state_d  = ACC_RD;
          cnt_d    = WAIT_INIT;
          rd_idx_d = pend_idx_q;
          rd_bad_d = pend_bad_q;
          pend_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q <= 1) begin
          state_d = S_RD_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_RESP: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_idx_q   <= '0;
      wr_dat_q   <= '0;
      wr_bad_q   <= 1'b0;
      rd_idx_q   <= '0;
      rd_bad_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_bad_q <= 1'b0;
      rd_has_q   <= 1'b0;
      rd_psn_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_idx_q   <= wr_idx_d;
      wr_dat_q   <= wr_dat_d;
      wr_bad_q   <= wr_bad_d;
      rd_idx_q   <= rd_idx_d;
      rd_bad_q   <= rd_bad_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_bad_q <= pend_bad_d;
      if (ram_re) begin
        rd_has_q <= 1'b1;
        rd_psn_q <= rd_bad_d;
      end
    end
  end

  // The RAM read register is the rd_data register: loaded entering RD_RESP.
  assign ram_we = rstn && (state_q == S_WR_RESP) && !wr_bad_q;
  assign ram_re = rstn && (state_d == S_RD_RESP);

  mem_resp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_idx_q),
    .wdata_i (wr_dat_q),
    .re_i    (ram_re),
    .raddr_i (rd_idx_d),
    .rdata_o (ram_rdata)
  );

  assign bus.wr_done  = (state_q == S_WR_RESP);
  assign bus.rd_valid = (state_q == S_RD_RESP);
  assign bus.rd_done  = (state_q == S_RD_RESP);
  assign bus.rd_data  = !rd_has_q ? '0 :
                        (rd_psn_q ? POISON : ram_rdata);

endmodule

// File: doc/mem_access_responder.md
MEM_ACCESS_RESPONDER -- requirements
Module: mem_access_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0008_1000, byte address of word 0 of the served window.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words served; power of two, 2..4096.
REQ-003 Parameter WAIT_CYCLES, default 3, extra cycles between request and response; range 0..15.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  one-cycle write request pulse.
REQ-007 wr_addr  input  32  write byte address, sampled with wr_en.
REQ-008 wr_data  input  32  write data, sampled with wr_en.
REQ-009 wr_done  output  1  one-cycle pulse, write committed.
REQ-010 rd_en  input  1  one-cycle read request pulse.
REQ-011 rd_addr  input  32  read byte address, sampled with rd_en.
REQ-012 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-013 rd_data  output  32  read data; holds last value between reads.
REQ-014 rd_done  output  1  one-cycle pulse, read complete; coincident with rd_valid.
REQ-015 err  output  1  one-cycle pulse coincident with wr_done/rd_done of a rejected access.

Function
REQ-016 FSM states SHALL be IDLE, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP, one-hot encoded; illegal encodings SHALL return to IDLE next cycle.
REQ-017 Requests SHALL be accepted only in IDLE, or from the pending-read latch; wr_en/rd_en in any other state SHALL be ignored.
REQ-018 Acceptance in cycle T: address/data captured; state -> *_WAIT with counter = WAIT_CYCLES, or directly *_RESP if WAIT_CYCLES = 0.
REQ-019 In *_WAIT the counter SHALL decrement each cycle; at counter = 1, state -> *_RESP; *_RESP SHALL occur in cycle T+WAIT_CYCLES+1.
REQ-020 *_RESP lasts exactly one cycle, then IDLE (or RD_WAIT/RD_RESP if a read is pending).
REQ-021 wr_done = 1 only in WR_RESP; the array word SHALL be updated on the edge ending WR_RESP.
REQ-022 rd_valid = rd_done = 1 only in RD_RESP; rd_data SHALL be registered on the edge entering RD_RESP.
REQ-023 Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits (modulo-DEPTH wrap).
REQ-024 wr_en and rd_en in the same IDLE cycle: write served first; read captured into a one-entry pending latch and accepted in the cycle after WR_RESP.
REQ-025 A read accepted after wr_done of the same address SHALL return the newly written data.
REQ-026 Without ADDR_CHECK_EN, err SHALL be constant 0.

Reset
REQ-027 rstn = 0 at any edge, including mid-transaction: state IDLE, counter 0, pending latch cleared, wr_done/rd_valid/rd_done/err = 0, rd_data = 0.
REQ-028 Array contents SHALL NOT be reset; an in-flight write SHALL be discarded.

Configuration
REQ-029 Macro ADDR_CHECK_EN: when defined, an access with addr < BASE_ADDR, addr >= BASE_ADDR + 4*DEPTH, or addr[1:0] != 0 is rejected: write suppressed, read returns 32'hDEAD_BEEF, err pulses with done, latency unchanged.
REQ-030 When undefined, no range/alignment check; all addresses map per REQ-023; no check logic synthesized.

Structure
REQ-031 Package mem_resp_pkg SHALL hold the state encodings, the poison constant 32'hDEAD_BEEF and the WAIT_CYCLES counter width.
REQ-032 Storage SHALL be sub-module mem_resp_ram: DEPTH x 32, one synchronous write port, one synchronous read port, no reset.

Verification
REQ-033 WAIT_CYCLES=3: wr_en at cycle 10, addr BASE+0x10, data 32'h1234_5678 -> wr_done only in cycle 14; then rd_en same addr -> rd_data 32'h1234_5678, rd_valid/rd_done pulse 4 cycles after request.
REQ-034 WAIT_CYCLES=0: rd_en at cycle T -> rd_done in T+1; back-to-back requests every 2 cycles all served.
REQ-035 wr_en and rd_en same cycle, same addr, data 32'hA5A5_A5A5 -> wr_done first, then rd_done returning 32'hA5A5_A5A5.
REQ-036 ADDR_CHECK_EN defined: rd_addr BASE+4*DEPTH -> rd_data 32'hDEAD_BEEF, err=1 with rd_done; wr_addr BASE+2 -> wr_done with err=1, array unchanged.
REQ-037 ADDR_CHECK_EN undefined: write to BASE+4*DEPTH, read BASE -> same data returned (wrap), err always 0.
REQ-038 rstn low during RD_WAIT -> no rd_done, all outputs 0 next cycle; after release, prior array contents readable.
